// File: rtl/br_issue_ctrl_if.sv
// br_issue_if: branch queue bundle; master drives dispatch/CDB/resolve (i_*), slave drives o_disp_rdy, o_is_* and o_count
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif
`ifndef ALU_OP_SEL
`define ALU_OP_SEL 4
`endif
interface br_issue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
);
  logic i_disp_vld, i_disp_is_jal, i_disp_is_jalr, i_disp_rs1_rdy, i_disp_rs2_rdy;
  logic [`ALU_OP_SEL-1:0] i_disp_alu_op_sel;
  logic [TAG_W-1:0] i_disp_rs1_tag, i_disp_rs2_tag, i_disp_rd_tag;
  logic [`RV32_DATA_WIDTH-1:0] i_disp_rs1, i_disp_rs2, i_disp_imm;
  logic [`RV32_PC_WIDTH-1:0] i_disp_pc, i_disp_pred_jmpaddr;
  logic o_disp_rdy;
  logic i_cdb_vld;
  logic [TAG_W-1:0] i_cdb_tag;
  logic [`RV32_DATA_WIDTH-1:0] i_cdb_data;
  logic o_is_vld, o_is_jal, o_is_jalr;
  logic [`ALU_OP_SEL-1:0] o_is_alu_op_sel;
  logic [`RV32_DATA_WIDTH-1:0] o_is_rs1, o_is_rs2, o_is_imm;
  logic [`RV32_PC_WIDTH-1:0] o_is_pc, o_is_pred_jmpaddr;
  logic [TAG_W-1:0] o_is_rd_tag;
  logic i_exfin, i_exfin_prmiss, i_flush;
  logic [$clog2(DEPTH):0] o_count;
  modport master (
    output i_disp_vld, i_disp_is_jal, i_disp_is_jalr, i_disp_rs1_rdy, i_disp_rs2_rdy, i_disp_alu_op_sel,
           i_disp_rs1_tag, i_disp_rs2_tag, i_disp_rd_tag, i_disp_rs1, i_disp_rs2, i_disp_imm,
           i_disp_pc, i_disp_pred_jmpaddr, i_cdb_vld, i_cdb_tag, i_cdb_data, i_exfin, i_exfin_prmiss, i_flush,
    input  o_disp_rdy, o_is_vld, o_is_jal, o_is_jalr, o_is_alu_op_sel, o_is_rs1, o_is_rs2, o_is_imm,
           o_is_pc, o_is_pred_jmpaddr, o_is_rd_tag, o_count
  );
  modport slave (
    input  i_disp_vld, i_disp_is_jal, i_disp_is_jalr, i_disp_rs1_rdy, i_disp_rs2_rdy, i_disp_alu_op_sel,
           i_disp_rs1_tag, i_disp_rs2_tag, i_disp_rd_tag, i_disp_rs1, i_disp_rs2, i_disp_imm,
           i_disp_pc, i_disp_pred_jmpaddr, i_cdb_vld, i_cdb_tag, i_cdb_data, i_exfin, i_exfin_prmiss, i_flush,
    output o_disp_rdy, o_is_vld, o_is_jal, o_is_jalr, o_is_alu_op_sel, o_is_rs1, o_is_rs2, o_is_imm,
           o_is_pc, o_is_pred_jmpaddr, o_is_rd_tag, o_count
  );
endinterface

// File: rtl/br_issue_ctrl.sv
// br_issue_ctrl: in-order branch issue queue (clk, async rst, bif: dispatch in, CDB wakeup, one-at-a-time issue, resolve/flush)
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif
`ifndef ALU_OP_SEL
`define ALU_OP_SEL 4
`endif
module br_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input logic clk,
  input logic rst,
  br_issue_if.slave bif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, RESOLVE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] vld, jal, jalr, rs1_rdy, rs2_rdy;
  logic [`ALU_OP_SEL-1:0] op [DEPTH];
  logic [TAG_W-1:0] rs1_tag [DEPTH];
  logic [TAG_W-1:0] rs2_tag [DEPTH];
  logic [TAG_W-1:0] rd_tag [DEPTH];
  logic [`RV32_DATA_WIDTH-1:0] rs1 [DEPTH];
  logic [`RV32_DATA_WIDTH-1:0] rs2 [DEPTH];
  logic [`RV32_DATA_WIDTH-1:0] imm [DEPTH];
  logic [`RV32_PC_WIDTH-1:0] pc [DEPTH];
  logic [`RV32_PC_WIDTH-1:0] pjmp [DEPTH];
  logic kill, rdy, push, pop, hit1, hit2;
  assign kill = bif.i_flush || (state == RESOLVE && bif.i_exfin && bif.i_exfin_prmiss);
  assign rdy = count < CW'(DEPTH) && !kill;
  assign push = bif.i_disp_vld && rdy;
  assign pop = state == IDLE && vld[head] && rs1_rdy[head] && rs2_rdy[head] && !bif.i_flush;
  assign hit1 = bif.i_cdb_vld && !bif.i_disp_rs1_rdy && bif.i_disp_rs1_tag == bif.i_cdb_tag;
  assign hit2 = bif.i_cdb_vld && !bif.i_disp_rs2_rdy && bif.i_disp_rs2_tag == bif.i_cdb_tag;
  assign bif.o_disp_rdy = rdy;
  assign bif.o_count = count;
  assign bif.o_is_vld = pop;
  assign bif.o_is_jal = jal[head];
  assign bif.o_is_jalr = jalr[head];
  assign bif.o_is_alu_op_sel = op[head];
  assign bif.o_is_rs1 = rs1[head];
  assign bif.o_is_rs2 = rs2[head];
  assign bif.o_is_imm = imm[head];
  assign bif.o_is_pc = pc[head];
  assign bif.o_is_pred_jmpaddr = pjmp[head];
  assign bif.o_is_rd_tag = rd_tag[head];
  always_comb begin
    state_nx = state;
    state_nx = kill ? IDLE : pop ? RESOLVE : (state == RESOLVE && bif.i_exfin) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
    end else begin
      state <= state_nx;
      if (kill) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        vld <= '0;
      end else begin
        if (push) begin
          vld[tail] <= 1'b1;
          tail <= tail + PW'(1);
        end
        if (pop) begin
          vld[head] <= 1'b0;
          head <= head + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (bif.i_cdb_vld && vld[i] && !rs1_rdy[i] && rs1_tag[i] == bif.i_cdb_tag) begin
        rs1[i] <= bif.i_cdb_data;
        rs1_rdy[i] <= 1'b1;
      end
      if (bif.i_cdb_vld && vld[i] && !rs2_rdy[i] && rs2_tag[i] == bif.i_cdb_tag) begin
        rs2[i] <= bif.i_cdb_data;
        rs2_rdy[i] <= 1'b1;
      end
    end
    if (push) begin
      jal[tail] <= bif.i_disp_is_jal;
      jalr[tail] <= bif.i_disp_is_jalr;
      op[tail] <= bif.i_disp_alu_op_sel;
      rs1_tag[tail] <= bif.i_disp_rs1_tag;
      rs2_tag[tail] <= bif.i_disp_rs2_tag;
      rd_tag[tail] <= bif.i_disp_rd_tag;
      rs1_rdy[tail] <= bif.i_disp_rs1_rdy || hit1;
      rs2_rdy[tail] <= bif.i_disp_rs2_rdy || hit2;
      rs1[tail] <= bif.i_disp_rs1_rdy ? bif.i_disp_rs1 : bif.i_cdb_data;
      rs2[tail] <= bif.i_disp_rs2_rdy ? bif.i_disp_rs2 : bif.i_cdb_data;
      imm[tail] <= bif.i_disp_imm;
      pc[tail] <= bif.i_disp_pc;
      pjmp[tail] <= bif.i_disp_pred_jmpaddr;
    end
  end
endmodule

// File: tb/tb_br_issue_ctrl.sv
// tb_br_issue_ctrl: directed scenarios plus randomized traffic against a queue-based reference model
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif
`ifndef ALU_OP_SEL
`define ALU_OP_SEL 4
`endif
module tb_br_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int miss = 0;
  always #5 clk = ~clk;
  br_issue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bif ();
  br_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bif(bif));
  typedef struct packed {
    logic jal;
    logic jalr;
    logic [`ALU_OP_SEL-1:0] op;
    logic r1;
    logic r2;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pj;
    logic [TAG_W-1:0] rd;
  } ent_t;
  ent_t q[$];
  bit busy;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    bif.i_disp_vld = 0; bif.i_disp_is_jal = 0; bif.i_disp_is_jalr = 0;
    bif.i_disp_rs1_rdy = 0; bif.i_disp_rs2_rdy = 0; bif.i_disp_alu_op_sel = '0;
    bif.i_disp_rs1_tag = '0; bif.i_disp_rs2_tag = '0; bif.i_disp_rd_tag = '0;
    bif.i_disp_rs1 = '0; bif.i_disp_rs2 = '0; bif.i_disp_imm = '0;
    bif.i_disp_pc = '0; bif.i_disp_pred_jmpaddr = '0;
    bif.i_cdb_vld = 0; bif.i_cdb_tag = '0; bif.i_cdb_data = '0;
    bif.i_exfin = 0; bif.i_exfin_prmiss = 0; bif.i_flush = 0;
  endtask
  task automatic disp(input logic r1, input logic r2, input logic [TAG_W-1:0] t, input logic [31:0] d, input logic [31:0] pc);
    bif.i_disp_vld = 1; bif.i_disp_rs1_rdy = r1; bif.i_disp_rs2_rdy = r2;
    bif.i_disp_rs1_tag = t; bif.i_disp_rs2_tag = t; bif.i_disp_rs1 = d; bif.i_disp_rs2 = ~d;
    bif.i_disp_pc = pc; bif.i_disp_imm = 32'h8; bif.i_disp_pred_jmpaddr = pc + 32'h8;
    bif.i_disp_rd_tag = 6'd3; bif.i_disp_alu_op_sel = 4'd1;
  endtask
  task automatic test_reset();
    #2;
    vec++; if (bif.o_is_vld !== 1'b0) begin miss++; $display("FAIL rst_is_vld: got %b exp 0", bif.o_is_vld); end
    vec++; if (bif.o_count !== 3'd0) begin miss++; $display("FAIL rst_count: got %0d exp 0", bif.o_count); end
    @(posedge clk);
    #1 rst = 0;
    tick();
    vec++; if (bif.o_disp_rdy !== 1'b1) begin miss++; $display("FAIL rst_disp_rdy: got %b exp 1", bif.o_disp_rdy); end
    vec++; if (bif.o_count !== 3'd0) begin miss++; $display("FAIL rst_count_after: got %0d exp 0", bif.o_count); end
  endtask
  task automatic test_single_issue();
    disp(1, 1, 0, 32'h11, 32'h100);
    #1;
    vec++; if (bif.o_disp_rdy !== 1'b1) begin miss++; $display("FAIL single_rdy: got %b exp 1", bif.o_disp_rdy); end
    tick(); clr(); #1;
    vec++; if (bif.o_is_vld !== 1'b1) begin miss++; $display("FAIL single_issue: got %b exp 1", bif.o_is_vld); end
    vec++; if (bif.o_count !== 3'd1) begin miss++; $display("FAIL single_count1: got %0d exp 1", bif.o_count); end
    vec++; if (bif.o_is_pc !== 32'h100) begin miss++; $display("FAIL single_pc: got %h exp 100", bif.o_is_pc); end
    vec++; if (bif.o_is_rs1 !== 32'h11) begin miss++; $display("FAIL single_rs1: got %h exp 11", bif.o_is_rs1); end
    tick();
    vec++; if (bif.o_is_vld !== 1'b0) begin miss++; $display("FAIL single_no_reissue: got %b exp 0", bif.o_is_vld); end
    vec++; if (bif.o_count !== 3'd0) begin miss++; $display("FAIL single_count0: got %0d exp 0", bif.o_count); end
    tick();
    vec++; if (bif.o_is_vld !== 1'b0) begin miss++; $display("FAIL single_resolve_hold: got %b exp 0", bif.o_is_vld); end
    bif.i_exfin = 1;
    tick(); clr();
  endtask
  task automatic test_wakeup();
    disp(0, 1, 6'd5, 32'h0, 32'h200);
    tick(); clr(); #1;
    vec++; if (bif.o_is_vld !== 1'b0) begin miss++; $display("FAIL wake_wait: got %b exp 0", bif.o_is_vld); end
    bif.i_cdb_vld = 1; bif.i_cdb_tag = 6'd5; bif.i_cdb_data = 32'h1234;
    #1;
    vec++; if (bif.o_is_vld !== 1'b0) begin miss++; $display("FAIL wake_same_cycle: got %b exp 0", bif.o_is_vld); end
    tick(); clr(); #1;
    vec++; if (bif.o_is_vld !== 1'b1) begin miss++; $display("FAIL wake_issue: got %b exp 1", bif.o_is_vld); end
    vec++; if (bif.o_is_rs1 !== 32'h1234) begin miss++; $display("FAIL wake_rs1: got %h exp 1234", bif.o_is_rs1); end
    tick();
    bif.i_exfin = 1;
    tick(); clr();
  endtask
  task automatic test_full_and_mispredict();
    for (int i = 0; i < DEPTH; i++) begin
      disp(0, 1, 6'd7, 32'(i), 32'h300 + 32'(i * 4));
      tick();
    end
    clr(); #1;
    vec++; if (bif.o_count !== 3'd4) begin miss++; $display("FAIL full_count: got %0d exp 4", bif.o_count); end
    vec++; if (bif.o_disp_rdy !== 1'b0) begin miss++; $display("FAIL full_rdy: got %b exp 0", bif.o_disp_rdy); end
    disp(1, 1, 0, 32'h0, 32'h3f0);
    tick(); clr(); #1;
    vec++; if (bif.o_count !== 3'd4) begin miss++; $display("FAIL full_fifth_dropped: got %0d exp 4", bif.o_count); end
    bif.i_cdb_vld = 1; bif.i_cdb_tag = 6'd7; bif.i_cdb_data = 32'h77;
    tick(); clr();
    disp(1, 1, 0, 32'h0, 32'h3f4);
    #1;
    vec++; if (bif.o_is_vld !== 1'b1) begin miss++; $display("FAIL full_issue: got %b exp 1", bif.o_is_vld); end
    vec++; if (bif.o_disp_rdy !== 1'b0) begin miss++; $display("FAIL full_slot_not_reused: got %b exp 0", bif.o_disp_rdy); end
    vec++; if (bif.o_is_rs1 !== 32'h77 || bif.o_is_pc !== 32'h300) begin miss++; $display("FAIL full_head: got rs1 %h pc %h exp 77 300", bif.o_is_rs1, bif.o_is_pc); end
    tick(); clr(); #1;
    vec++; if (bif.o_count !== 3'd3) begin miss++; $display("FAIL full_count3: got %0d exp 3", bif.o_count); end
    vec++; if (bif.o_disp_rdy !== 1'b1) begin miss++; $display("FAIL full_rdy_again: got %b exp 1", bif.o_disp_rdy); end
    bif.i_exfin = 1; bif.i_exfin_prmiss = 1;
    disp(1, 1, 0, 32'h0, 32'h3f8);
    #1;
    vec++; if (bif.o_disp_rdy !== 1'b0) begin miss++; $display("FAIL prmiss_rdy: got %b exp 0", bif.o_disp_rdy); end
    tick(); clr(); #1;
    vec++; if (bif.o_count !== 3'd0) begin miss++; $display("FAIL prmiss_count: got %0d exp 0", bif.o_count); end
    vec++; if (bif.o_is_vld !== 1'b0) begin miss++; $display("FAIL prmiss_no_issue: got %b exp 0", bif.o_is_vld); end
    tick();
    vec++; if (bif.o_is_vld !== 1'b0) begin miss++; $display("FAIL prmiss_no_issue2: got %b exp 0", bif.o_is_vld); end
  endtask
  task automatic test_flush();
    disp(0, 1, 6'd9, 32'h0, 32'h400);
    bif.i_cdb_vld = 1; bif.i_cdb_tag = 6'd9; bif.i_cdb_data = 32'h99; bif.i_flush = 1;
    #1;
    vec++; if (bif.o_disp_rdy !== 1'b0) begin miss++; $display("FAIL flush_rdy: got %b exp 0", bif.o_disp_rdy); end
    tick(); clr(); #1;
    vec++; if (bif.o_count !== 3'd0) begin miss++; $display("FAIL flush_count: got %0d exp 0", bif.o_count); end
    disp(1, 1, 0, 32'h5, 32'h500);
    tick(); clr(); bif.i_flush = 1; #1;
    vec++; if (bif.o_is_vld !== 1'b0) begin miss++; $display("FAIL flush_over_issue: got %b exp 0", bif.o_is_vld); end
    tick(); clr(); #1;
    vec++; if (bif.o_count !== 3'd0) begin miss++; $display("FAIL flush_count2: got %0d exp 0", bif.o_count); end
    disp(1, 1, 0, 32'h6, 32'h600);
    tick(); clr(); #1;
    vec++; if (bif.o_is_vld !== 1'b1 || bif.o_is_pc !== 32'h600) begin miss++; $display("FAIL flush_idle_issue: got vld %b pc %h exp 1 600", bif.o_is_vld, bif.o_is_pc); end
    tick();
    bif.i_exfin = 1;
    tick(); clr();
  endtask
  task automatic test_reset_in_resolve();
    disp(1, 1, 0, 32'h1, 32'h700); tick();
    disp(1, 1, 0, 32'h2, 32'h704); tick();
    disp(1, 1, 0, 32'h3, 32'h708); tick();
    clr(); #1;
    vec++; if (bif.o_count !== 3'd2 || bif.o_is_vld !== 1'b0) begin miss++; $display("FAIL rr_pre: got count %0d vld %b exp 2 0", bif.o_count, bif.o_is_vld); end
    rst = 1;
    #1;
    vec++; if (bif.o_count !== 3'd0 || bif.o_is_vld !== 1'b0 || bif.o_disp_rdy !== 1'b1) begin miss++; $display("FAIL rr_async: got count %0d vld %b rdy %b exp 0 0 1", bif.o_count, bif.o_is_vld, bif.o_disp_rdy); end
    tick();
    rst = 0;
    bif.i_exfin = 1;
    tick(); clr(); #1;
    vec++; if (bif.o_count !== 3'd0 || bif.o_is_vld !== 1'b0) begin miss++; $display("FAIL rr_exfin_ignored: got count %0d vld %b exp 0 0", bif.o_count, bif.o_is_vld); end
    disp(1, 1, 0, 32'h9, 32'h800);
    tick(); clr(); #1;
    vec++; if (bif.o_is_vld !== 1'b1 || bif.o_is_pc !== 32'h800) begin miss++; $display("FAIL rr_idle_issue: got vld %b pc %h exp 1 800", bif.o_is_vld, bif.o_is_pc); end
  endtask
  task automatic test_random();
    ent_t e;
    logic kill, e_rdy, e_iss;
    rst = 1;
    tick();
    rst = 0;
    q.delete();
    busy = 0;
    for (int n = 0; n < 1500; n++) begin
      bif.i_disp_vld = $urandom_range(0, 9) < 6;
      bif.i_disp_is_jal = 1'($urandom_range(0, 1));
      bif.i_disp_is_jalr = 1'($urandom_range(0, 1));
      bif.i_disp_alu_op_sel = 4'($urandom_range(0, 15));
      bif.i_disp_rs1_rdy = 1'($urandom_range(0, 1));
      bif.i_disp_rs2_rdy = 1'($urandom_range(0, 1));
      bif.i_disp_rs1_tag = TAG_W'($urandom_range(0, 3));
      bif.i_disp_rs2_tag = TAG_W'($urandom_range(0, 3));
      bif.i_disp_rd_tag = TAG_W'($urandom_range(0, 63));
      bif.i_disp_rs1 = $urandom; bif.i_disp_rs2 = $urandom; bif.i_disp_imm = $urandom;
      bif.i_disp_pc = $urandom; bif.i_disp_pred_jmpaddr = $urandom;
      bif.i_cdb_vld = $urandom_range(0, 9) < 4;
      bif.i_cdb_tag = TAG_W'($urandom_range(0, 3));
      bif.i_cdb_data = $urandom;
      bif.i_flush = $urandom_range(0, 49) == 0;
      bif.i_exfin = $urandom_range(0, 9) < 3;
      bif.i_exfin_prmiss = $urandom_range(0, 3) == 0;
      #1;
      kill = bif.i_flush || (busy && bif.i_exfin && bif.i_exfin_prmiss);
      e_rdy = q.size() < DEPTH && !kill;
      e_iss = !busy && q.size() > 0 && !bif.i_flush;
      if (e_iss) e_iss = q[0].r1 && q[0].r2;
      vec++; if (bif.o_disp_rdy !== e_rdy) begin miss++; $display("FAIL rnd_rdy cyc %0d: got %b exp %b", n, bif.o_disp_rdy, e_rdy); end
      vec++; if (bif.o_is_vld !== e_iss) begin miss++; $display("FAIL rnd_is_vld cyc %0d: got %b exp %b", n, bif.o_is_vld, e_iss); end
      vec++; if (bif.o_count !== CW'(q.size())) begin miss++; $display("FAIL rnd_count cyc %0d: got %0d exp %0d", n, bif.o_count, q.size()); end
      if (e_iss) begin
        vec++;
        if ({bif.o_is_rs1, bif.o_is_rs2, bif.o_is_pc, bif.o_is_imm, bif.o_is_pred_jmpaddr, bif.o_is_rd_tag, bif.o_is_jal, bif.o_is_jalr, bif.o_is_alu_op_sel}
            !== {q[0].d1, q[0].d2, q[0].pc, q[0].imm, q[0].pj, q[0].rd, q[0].jal, q[0].jalr, q[0].op}) begin
          miss++;
          $display("FAIL rnd_payload cyc %0d: got rs1 %h rs2 %h pc %h exp rs1 %h rs2 %h pc %h", n, bif.o_is_rs1, bif.o_is_rs2, bif.o_is_pc, q[0].d1, q[0].d2, q[0].pc);
        end
      end
      if (kill) begin
        q.delete();
        busy = 0;
      end else begin
        if (e_iss) begin
          void'(q.pop_front());
          busy = 1;
        end else if (busy && bif.i_exfin) busy = 0;
        if (bif.i_cdb_vld)
          foreach (q[i]) begin
            e = q[i];
            if (!e.r1 && e.t1 == bif.i_cdb_tag) begin e.r1 = 1; e.d1 = bif.i_cdb_data; end
            if (!e.r2 && e.t2 == bif.i_cdb_tag) begin e.r2 = 1; e.d2 = bif.i_cdb_data; end
            q[i] = e;
          end
        if (bif.i_disp_vld && e_rdy) begin
          e.jal = bif.i_disp_is_jal; e.jalr = bif.i_disp_is_jalr; e.op = bif.i_disp_alu_op_sel;
          e.t1 = bif.i_disp_rs1_tag; e.t2 = bif.i_disp_rs2_tag; e.rd = bif.i_disp_rd_tag;
          e.r1 = bif.i_disp_rs1_rdy || (bif.i_cdb_vld && bif.i_disp_rs1_tag == bif.i_cdb_tag);
          e.r2 = bif.i_disp_rs2_rdy || (bif.i_cdb_vld && bif.i_disp_rs2_tag == bif.i_cdb_tag);
          e.d1 = bif.i_disp_rs1_rdy ? bif.i_disp_rs1 : bif.i_cdb_data;
          e.d2 = bif.i_disp_rs2_rdy ? bif.i_disp_rs2 : bif.i_cdb_data;
          e.pc = bif.i_disp_pc; e.imm = bif.i_disp_imm; e.pj = bif.i_disp_pred_jmpaddr;
          q.push_back(e);
        end
      end
      tick();
    end
    clr();
  endtask
  initial begin
    clr();
    test_reset();
    test_single_issue();
    test_wakeup();
    test_full_and_mispredict();
    test_flush();
    test_reset_in_resolve();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/br_issue_ctrl.md
BR_ISSUE_CTRL -- requirements
Module: br_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of branch queue entries (power of 2, >=2).
REQ-002 SHALL have parameter TAG_W, default 6, meaning physical-register tag width.
REQ-003 SHALL have ports clk (in, 1, single clock) and rst (in, 1, asynchronous active-high reset).
REQ-004 SHALL have dispatch ports:
- i_disp_vld (in, 1): dispatch request.
- i_disp_is_jal, i_disp_is_jalr (in, 1 each).
- i_disp_alu_op_sel (in, `ALU_OP_SEL).
- i_disp_rs1_rdy / i_disp_rs2_rdy (in, 1 each): operand value valid.
- i_disp_rs1_tag / i_disp_rs2_tag (in, TAG_W).
- i_disp_rs1 / i_disp_rs2 (in, `RV32_DATA_WIDTH).
- i_disp_pc, i_disp_pred_jmpaddr (in, `RV32_PC_WIDTH); i_disp_imm (in, `RV32_DATA_WIDTH); i_disp_rd_tag (in, TAG_W).
- o_disp_rdy (out, 1): queue can accept.
REQ-005 SHALL have wakeup ports i_cdb_vld (in, 1), i_cdb_tag (in, TAG_W), i_cdb_data (in, `RV32_DATA_WIDTH).
REQ-006 SHALL have issue ports o_is_vld (out, 1) plus o_is_jal, o_is_jalr, o_is_alu_op_sel, o_is_rs1, o_is_rs2, o_is_pc, o_is_imm, o_is_pred_jmpaddr, o_is_rd_tag, each the width of its matching dispatch field.
REQ-007 SHALL have resolve ports:
- i_exfin (in, 1), i_exfin_prmiss (in, 1): from branch unit.
- i_flush (in, 1): external flush.
- o_count (out, clog2(DEPTH)+1): occupied entries.

Function
REQ-008 SHALL hold entries in an in-order circular queue with head/tail pointers that wrap modulo DEPTH.
REQ-009 SHALL accept a dispatch when i_disp_vld && o_disp_rdy; o_disp_rdy = (count < DEPTH) && !i_flush && !flush_pending.
REQ-010 SHALL capture operand data on dispatch from i_cdb_data when i_cdb_vld, the operand is not ready, and its tag matches i_cdb_tag; the operand is then stored ready.
REQ-011 SHALL, each cycle, for every valid entry with a non-ready operand whose tag equals i_cdb_tag while i_cdb_vld, write i_cdb_data and set ready.
REQ-012 SHALL use FSM states IDLE and RESOLVE.
REQ-013 SHALL, in IDLE, assert o_is_vld for exactly one cycle when the head entry is valid and both operands are ready in registered state; the same cycle SHALL pop the head and enter RESOLVE.
REQ-014 SHALL NOT issue from a CDB value arriving in the same cycle; minimum wakeup-to-issue latency is 1 cycle.
REQ-015 SHALL, in RESOLVE, issue nothing; on i_exfin && !i_exfin_prmiss return to IDLE.
REQ-016 SHALL, on i_exfin && i_exfin_prmiss, invalidate all entries, reset head=tail=0 and count=0 on the next edge, and return to IDLE; dispatch that cycle is dropped.
REQ-017 SHALL treat i_flush identically to REQ-016 in any state; flush takes priority over dispatch, wakeup and issue in the same cycle.
REQ-018 SHALL handle dispatch and issue in the same cycle: count is unchanged, and when the queue was full the freed slot is not reusable until the next cycle.
REQ-019 SHALL drive o_is_* payload fields from the head entry; their value when o_is_vld=0 is don't-care.
REQ-020 SHALL ignore i_exfin while in IDLE.

Reset
REQ-021 SHALL, while rst is high, asynchronously clear all entry valid bits, head=tail=0, state=IDLE, o_is_vld=0, o_count=0 and o_disp_rdy=1 one cycle after release.
REQ-022 SHALL, on reset mid-RESOLVE, discard the outstanding branch; a later i_exfin is ignored per REQ-020.

Verification
REQ-023 Dispatch a BEQ with both operands ready into an empty queue -> o_is_vld=1 the next cycle, o_count 1->0, no further issue until i_exfin.
REQ-024 Dispatch with rs1 not ready, tag 5, then i_cdb_vld with tag 5 and data 0x1234 -> issue one cycle after the CDB cycle with o_is_rs1=0x1234.
REQ-025 Dispatch 4 entries (DEPTH=4) -> o_disp_rdy=0, and a 5th dispatch is not accepted; one issue -> o_disp_rdy=1 the following cycle.
REQ-026 Three queued ready branches, first resolves with i_exfin_prmiss=1 -> o_count=0 the next cycle and no issue of the remaining two.
REQ-027 i_flush in the same cycle as i_disp_vld and a CDB match -> nothing enqueued, o_count=0, state IDLE.
REQ-028 Assert rst while in RESOLVE with 2 entries queued -> all outputs at reset values immediately; a subsequent i_exfin causes no effect.
